afe_spi_multi_master: RTL

- Parametrised serial-control engine for the AFE attenuator/switch shift registers (latch-enable framing, write-only) and the AMI converters (chip-select framing, with readback).
- Generalises the fixed two-channel AFE/AMI SPI wiring to CHANNEL_COUNT channels, per-command word width and per-command framing mode.
- Sits in the sysClk domain between the processor GPIO/CSR interface and the board SPI pins.

---
 rtl/afe_spi_multi_master_if.sv | 26 ++
 rtl/afe_spi_multi_master.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/afe_spi_multi_master_if.sv
// Command/response bus between the processor-side CSR logic and the SPI engine.
interface afe_spi_multi_master_if #(
  parameter int MAX_WIDTH         = 32,
  parameter int CHANNEL_SEL_WIDTH = 1,
  parameter int LEN_WIDTH         = 6
);
  logic                         cmdValid;
  logic                         cmdReady;
  logic [CHANNEL_SEL_WIDTH-1:0] cmdChannel;
  logic [LEN_WIDTH-1:0]         cmdLength;
  logic                         cmdMode;
  logic [MAX_WIDTH-1:0]         cmdData;
  logic                         done;
  logic                         cmdErr;
  logic [MAX_WIDTH-1:0]         rdData;

  modport master (
    output cmdValid, cmdChannel, cmdLength, cmdMode, cmdData,
    input  cmdReady, done, cmdErr, rdData
  );

  modport slave (
    input  cmdValid, cmdChannel, cmdLength, cmdMode, cmdData,
    output cmdReady, done, cmdErr, rdData
  );
endinterface

// File: rtl/afe_spi_multi_master.sv
// Multi-channel SPI engine: LE-framed writes for AFE shift registers and
// CSB-framed write/readback for AMI converters, CPOL=0/CPHA=0.
module afe_spi_multi_master #(
  parameter int CHANNEL_COUNT     = 2,
  parameter int MAX_WIDTH         = 32,
  parameter int CLK_DIV           = 4,
  parameter int CHANNEL_SEL_WIDTH = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
  parameter int LEN_WIDTH         = $clog2(MAX_WIDTH + 1)
) (
  input  logic                     sysClk,
  input  logic                     sysReset,
  afe_spi_multi_master_if.slave    cmd,
  output logic [CHANNEL_COUNT-1:0] spiClk,
  output logic [CHANNEL_COUNT-1:0] spiSdi,
  output logic [CHANNEL_COUNT-1:0] spiLe,
  output logic [CHANNEL_COUNT-1:0] spiCsb,
  input  logic [CHANNEL_COUNT-1:0] spiSdo
);
  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LATCH} state_e;

  state_e                   state_q;
  logic [DIV_W-1:0]         div_q;
  logic                     high_q;
  logic                     mode_q;
  logic [LEN_WIDTH-1:0]     bitcnt_q;
  logic [CHANNEL_COUNT-1:0] sel_q;
  logic [CHANNEL_COUNT-1:0] sdo_meta_q, sdo_sync_q;
  logic [CHANNEL_COUNT-1:0] spiClk_q, spiSdi_q, spiLe_q, spiCsb_q;
  logic [MAX_WIDTH-1:0]     tx_q, rx_q, rdData_q;
  logic                     cmdReady_q, done_q, cmdErr_q;

  logic [CHANNEL_SEL_WIDTH-1:0] ch_in;
  logic [CHANNEL_COUNT-1:0]     sel_d;
  logic [MAX_WIDTH-1:0]         tx_d;
  logic                         cmd_bad, div_last, sdo_bit;

  // Write word is left-aligned on accept so every frame shifts out of the MSB.
  always_comb begin
    ch_in    = cmd.cmdChannel;
    cmd_bad  = (cmd.cmdLength == '0) ||
               (32'(cmd.cmdLength) > MAX_WIDTH) ||
               (32'(ch_in) >= CHANNEL_COUNT);
    tx_d     = cmd.cmdData << (MAX_WIDTH - 32'(cmd.cmdLength));
    sel_d    = CHANNEL_COUNT'(1) << ch_in;
    div_last = (div_q == DIV_W'(CLK_DIV - 1));
    sdo_bit  = |(sdo_sync_q & sel_q);
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      high_q     <= 1'b0;
      mode_q     <= 1'b0;
      bitcnt_q   <= '0;
      sel_q      <= '0;
      sdo_meta_q <= '0;
      sdo_sync_q <= '0;
      spiClk_q   <= '0;
      spiSdi_q   <= '0;
      spiLe_q    <= '0;
      spiCsb_q   <= '1;
      tx_q       <= '0;
      rx_q       <= '0;
      rdData_q   <= '0;
      cmdReady_q <= 1'b1;
      done_q     <= 1'b0;
      cmdErr_q   <= 1'b0;
    end else begin
      sdo_meta_q <= spiSdo;
      sdo_sync_q <= sdo_meta_q;
      done_q     <= 1'b0;
      cmdErr_q   <= 1'b0;
      div_q      <= (state_q == IDLE || div_last) ? '0 : div_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (cmd.cmdValid) begin
            if (cmd_bad) begin
              done_q   <= 1'b1;
              cmdErr_q <= 1'b1;
            end else begin
              state_q    <= SETUP;
              cmdReady_q <= 1'b0;
              mode_q     <= cmd.cmdMode;
              bitcnt_q   <= cmd.cmdLength - 1'b1;
              sel_q      <= sel_d;
              tx_q       <= tx_d;
              rx_q       <= '0;
              spiSdi_q   <= tx_d[MAX_WIDTH-1] ? sel_d : '0;
              if (cmd.cmdMode) spiCsb_q <= ~sel_d;
            end
          end
        end

        SETUP: begin
          if (div_last) begin
            state_q  <= SHIFT;
            high_q   <= 1'b1;
            spiClk_q <= sel_q;
          end
        end

        // Sample at the end of the high phase; the next bit is driven from the
        // first low-phase cycle, and the last bit stays on the line.
        SHIFT: begin
          if (div_last) begin
            if (high_q) begin
              rx_q     <= {rx_q[MAX_WIDTH-2:0], sdo_bit};
              high_q   <= 1'b0;
              spiClk_q <= '0;
              if (bitcnt_q != '0) begin
                tx_q     <= tx_q << 1;
                spiSdi_q <= tx_q[MAX_WIDTH-2] ? sel_q : '0;
              end
            end else if (bitcnt_q == '0) begin
              state_q <= HOLD;
            end else begin
              bitcnt_q <= bitcnt_q - 1'b1;
              high_q   <= 1'b1;
              spiClk_q <= sel_q;
            end
          end
        end

        HOLD: begin
          if (div_last) begin
            if (!mode_q) begin
              state_q <= LATCH;
              spiLe_q <= sel_q;
            end else begin
              state_q    <= IDLE;
              done_q     <= 1'b1;
              cmdReady_q <= 1'b1;
              rdData_q   <= rx_q;
              spiSdi_q   <= '0;
              spiCsb_q   <= '1;
            end
          end
        end

        LATCH: begin
          if (div_last) begin
            state_q    <= IDLE;
            done_q     <= 1'b1;
            cmdReady_q <= 1'b1;
            rdData_q   <= '0;
            spiSdi_q   <= '0;
            spiLe_q    <= '0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign spiClk       = spiClk_q;
  assign spiSdi       = spiSdi_q;
  assign spiLe        = spiLe_q;
  assign spiCsb       = spiCsb_q;
  assign cmd.cmdReady = cmdReady_q;
  assign cmd.done     = done_q;
  assign cmd.cmdErr   = cmdErr_q;
  assign cmd.rdData   = rdData_q;
endmodule
